// File: rtl/hazard_ctrl_if.sv
// Hazard scheduler bundle: ID/EX decode facts in, pipeline enables/flushes and MDU handshake out.
// master = pipeline datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if;
  logic [4:0]  rsID;
  logic [4:0]  rtID;
  logic        useRtID;
  logic        mdUseID;
  logic [4:0]  rdEX;
  logic        lwEX;
  logic        GPRWrEX;
  logic        mdOpEX;
  logic        brTakenEX;
  logic        PCWr;
  logic        IFIDWr;
  logic        IFIDFlush;
  logic        IDEXFlush;
  logic        mdu_go;
  logic        mdBusy;
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  modport master (
    output rsID, rtID, useRtID, mdUseID, rdEX, lwEX, GPRWrEX, mdOpEX, brTakenEX,
    input  PCWr, IFIDWr, IFIDFlush, IDEXFlush, mdu_go, mdBusy, stallCnt, flushCnt
  );

  modport slave (
    input  rsID, rtID, useRtID, mdUseID, rdEX, lwEX, GPRWrEX, mdOpEX, brTakenEX,
    output PCWr, IFIDWr, IFIDFlush, IDEXFlush, mdu_go, mdBusy, stallCnt, flushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS32 hazard scheduler: load-use stall, taken-branch flush, MDU busy tracking.
// Controls are combinational (0 latency); define STALL_CNT_EN for stall/flush event counters.
module hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 6
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] MDWAIT = 1'b1;
  localparam logic [CNT_W-1:0] MD_CNT_INIT = CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] MD_CNT_LAST = CNT_W'(1);

  logic [0:0]       state;
  logic [CNT_W-1:0] mdCnt;
  logic             busy;
  logic             ldHaz;
  logic             mdHaz;
  logic             go;
  logic             pcwr;
  logic             ifidwr;
  logic             ifidflush;
  logic             idexflush;

  assign busy  = (state == MDWAIT);
  assign ldHaz = hz.lwEX & hz.GPRWrEX & (hz.rdEX != 5'd0) &
                 ((hz.rdEX == hz.rsID) | (hz.useRtID & (hz.rdEX == hz.rtID)));
  assign mdHaz = busy & hz.mdUseID;
  assign go    = hz.mdOpEX & ~busy & ~rst;

  // A taken branch squashes the ID instruction, so any stall it would need is moot.
  always_comb begin
    pcwr      = 1'b1;
    ifidwr    = 1'b1;
    ifidflush = 1'b0;
    idexflush = 1'b0;
    if (!rst) begin
      if (hz.brTakenEX) begin
        ifidflush = 1'b1;
        idexflush = 1'b1;
      end else if (ldHaz | mdHaz) begin
        pcwr      = 1'b0;
        ifidwr    = 1'b0;
        idexflush = 1'b1;
      end
    end
  end

  // Busy window is MD_LAT-1 cycles after the go pulse; branches never abort it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      mdCnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (go) begin
            state <= MDWAIT;
            mdCnt <= MD_CNT_INIT;
          end
        end
        MDWAIT: begin
          if (mdCnt == MD_CNT_LAST) begin
            state <= RUN;
            mdCnt <= '0;
          end else begin
            mdCnt <= mdCnt - 1'b1;
          end
        end
        default: begin
          state <= RUN;
          mdCnt <= '0;
        end
      endcase
    end
  end

  assign hz.PCWr      = pcwr;
  assign hz.IFIDWr    = ifidwr;
  assign hz.IFIDFlush = ifidflush;
  assign hz.IDEXFlush = idexflush;
  assign hz.mdu_go    = go;
  assign hz.mdBusy    = busy;

`ifdef STALL_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pcwr)
        stall_q <= stall_q + 32'd1;
      if (ifidflush)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign hz.stallCnt = stall_q;
  assign hz.flushCnt = flush_q;
`else
  assign hz.stallCnt = '0;
  assign hz.flushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MD_LAT=4): directed cases plus randomized traffic vs a behavioural model.
module tb_hazard_ctrl;
  localparam int MD_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: cycles of MDU busy remaining, plus event counts.
  int          m_busy  = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  typedef struct packed {
    logic pcwr;
    logic ifidwr;
    logic ifidf;
    logic idexf;
    logic go;
    logic busy;
  } exp_t;

  function automatic exp_t expect_now();
    exp_t e;
    logic ld, md, bsy;
    bsy = (m_busy > 0);
    ld  = hz.lwEX && hz.GPRWrEX && hz.rdEX != 0 &&
          (hz.rdEX == hz.rsID || (hz.useRtID && hz.rdEX == hz.rtID));
    md  = bsy && hz.mdUseID;
    e   = '{pcwr: 1'b1, ifidwr: 1'b1, ifidf: 1'b0, idexf: 1'b0, go: 1'b0, busy: 1'b0};
    if (!rst) begin
      e.busy = bsy;
      e.go   = hz.mdOpEX && !bsy;
      if (hz.brTakenEX) begin
        e.ifidf = 1'b1;
        e.idexf = 1'b1;
      end else if (ld || md) begin
        e.pcwr   = 1'b0;
        e.ifidwr = 1'b0;
        e.idexf  = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      m_busy  = 0;
      m_stall = '0;
      m_flush = '0;
    end else begin
      e = expect_now();
      if (!e.pcwr) m_stall = m_stall + 32'd1;
      if (e.ifidf) m_flush = m_flush + 32'd1;
      if (m_busy > 0) m_busy = m_busy - 1;
      else if (e.go) m_busy = MD_LAT - 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = expect_now();
    chk("PCWr",      hz.PCWr,      e.pcwr);
    chk("IFIDWr",    hz.IFIDWr,    e.ifidwr);
    chk("IFIDFlush", hz.IFIDFlush, e.ifidf);
    chk("IDEXFlush", hz.IDEXFlush, e.idexf);
    chk("mdu_go",    hz.mdu_go,    e.go);
    chk("mdBusy",    hz.mdBusy,    e.busy);
`ifdef STALL_CNT_EN
    chk("stallCnt",  hz.stallCnt,  m_stall);
    chk("flushCnt",  hz.flushCnt,  m_flush);
`else
    chk("stallCnt",  hz.stallCnt,  32'd0);
    chk("flushCnt",  hz.flushCnt,  32'd0);
`endif
  end

  task automatic idle();
    hz.rsID = 5'd0; hz.rtID = 5'd0; hz.useRtID = 1'b0; hz.mdUseID = 1'b0;
    hz.rdEX = 5'd0; hz.lwEX = 1'b0; hz.GPRWrEX = 1'b0; hz.mdOpEX = 1'b0;
    hz.brTakenEX = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    chk("rst_PCWr",   hz.PCWr,   32'd1);
    chk("rst_IFIDWr", hz.IFIDWr, 32'd1);
    chk("rst_mdBusy", hz.mdBusy, 32'd0);
    chk("rst_stall",  hz.stallCnt, 32'd0);
    step(); step();
    rst = 1'b0;

    // Load-use: exactly one bubble.
    step();
    hz.lwEX = 1'b1; hz.GPRWrEX = 1'b1; hz.rdEX = 5'd8; hz.rsID = 5'd8;
    #1;
    chk("lu_PCWr",   hz.PCWr,      32'd0);
    chk("lu_IFIDWr", hz.IFIDWr,    32'd0);
    chk("lu_bubble", hz.IDEXFlush, 32'd1);
    step();
    idle();
    #1;
    chk("lu_next_PCWr",  hz.PCWr,      32'd1);
    chk("lu_next_flush", hz.IDEXFlush, 32'd0);

    // $zero destination never stalls.
    step();
    hz.lwEX = 1'b1; hz.GPRWrEX = 1'b1; hz.rdEX = 5'd0; hz.rsID = 5'd0;
    #1;
    chk("zero_PCWr", hz.PCWr, 32'd1);

    // Branch beats load-use.
    step();
    hz.lwEX = 1'b1; hz.GPRWrEX = 1'b1; hz.rdEX = 5'd9; hz.rtID = 5'd9; hz.useRtID = 1'b1;
    hz.brTakenEX = 1'b1;
    #1;
    chk("br_IFIDFlush", hz.IFIDFlush, 32'd1);
    chk("br_IDEXFlush", hz.IDEXFlush, 32'd1);
    chk("br_PCWr",      hz.PCWr,      32'd1);
    step();
    idle();
    #1;
`ifdef STALL_CNT_EN
    chk("cnt_stall", hz.stallCnt, 32'd1);
    chk("cnt_flush", hz.flushCnt, 32'd1);
`else
    chk("cnt_stall", hz.stallCnt, 32'd0);
    chk("cnt_flush", hz.flushCnt, 32'd0);
`endif

    // MDU: go pulse, then MD_LAT-1 busy cycles stalling a HI/LO reader.
    step();
    hz.mdOpEX = 1'b1;
    #1;
    chk("md_go",       hz.mdu_go, 32'd1);
    chk("md_go_busy",  hz.mdBusy, 32'd0);
    step();
    hz.mdOpEX = 1'b0; hz.mdUseID = 1'b1;
    for (int i = 0; i < MD_LAT - 1; i++) begin
      #1;
      chk("md_busy", hz.mdBusy, 32'd1);
      chk("md_stall", hz.PCWr,  32'd0);
      step();
    end
    #1;
    chk("md_done_busy", hz.mdBusy, 32'd0);
    chk("md_done_PCWr", hz.PCWr,   32'd1);
    step();
    idle();

    // Async reset in the 2nd busy cycle clears immediately.
    step();
    hz.mdOpEX = 1'b1;
    step();
    hz.mdOpEX = 1'b0;
    step();
    hz.mdUseID = 1'b1;
    #1;
    chk("rstmd_pre_busy", hz.mdBusy, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmd_busy", hz.mdBusy, 32'd0);
    chk("rstmd_PCWr", hz.PCWr,   32'd1);
    rst = 1'b0;
    step();
    idle();

    for (int c = 0; c < 3000; c++) begin
      step();
      rst          = ($urandom_range(0, 99) == 0);
      hz.rsID      = 5'($urandom_range(0, 3));
      hz.rtID      = 5'($urandom_range(0, 3));
      hz.rdEX      = 5'($urandom_range(0, 3));
      hz.useRtID   = 1'($urandom_range(0, 1));
      hz.mdUseID   = 1'($urandom_range(0, 1));
      hz.lwEX      = 1'($urandom_range(0, 1));
      hz.GPRWrEX   = ($urandom_range(0, 3) != 0);
      hz.mdOpEX    = ($urandom_range(0, 5) == 0);
      hz.brTakenEX = ($urandom_range(0, 4) == 0);
    end
    step();
    rst = 1'b0;
    idle();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
